// File: rtl/l1_dcache_if.sv
// PicoRV32-style native memory bus: request fields flow master->slave and
// the completion pulse with read data flows back.
interface l1_dcache_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 cache between the
// PicoRV32 native port and a delayed main memory, with hit/miss counters.
module l1_dcache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         reset,
    l1_dcache_if.slave   cpu,
    l1_dcache_if.master  mem,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int WW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TL = 2 + WW + IW;
    localparam int TW = 28 - TL;
    localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_REFILL = 3'd2,
        S_WRITE  = 3'd3,
        S_BYPASS = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_r;
    logic [31:0]     addr_r;
    logic [31:0]     wdata_r;
    logic [3:0]      wstrb_r;
    logic            instr_r;
    logic [WW-1:0]   cnt_r;
    logic            refilled_r;
    logic [NUM_LINES-1:0] valid_r;
    logic [TW-1:0]   tag_r  [NUM_LINES];
    logic [31:0]     data_r [NUM_LINES][LINE_WORDS];

    logic            cpu_ready_r;
    logic [31:0]     cpu_rdata_r;
    logic            mem_valid_r;
    logic            mem_instr_r;
    logic [31:0]     mem_addr_r;
    logic [31:0]     mem_wdata_r;
    logic [3:0]      mem_wstrb_r;
    logic [31:0]     hit_count_r;
    logic [31:0]     miss_count_r;

    logic [IW-1:0]   idx_s;
    logic [WW-1:0]   word_s;
    logic [TW-1:0]   tag_s;
    logic            hit_s;
    logic            mem_done_s;
    logic            last_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                 input logic [31:0] new_w,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Address decode and hit detection on the latched request
    always_comb begin
        idx_s      = addr_r[TL-1:2+WW];
        word_s     = addr_r[2+WW-1:2];
        tag_s      = addr_r[27:TL];
        hit_s      = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
        mem_done_s = mem_valid_r && mem.ready;
        last_s     = (cnt_r == LAST_WORD);
    end

    // Control FSM with all bus outputs, valid bits and counters registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            addr_r       <= 32'h0;
            wdata_r      <= 32'h0;
            wstrb_r      <= 4'h0;
            instr_r      <= 1'b0;
            cnt_r        <= '0;
            refilled_r   <= 1'b0;
            valid_r      <= '0;
            cpu_ready_r  <= 1'b0;
            cpu_rdata_r  <= 32'h0;
            mem_valid_r  <= 1'b0;
            mem_instr_r  <= 1'b0;
            mem_addr_r   <= 32'h0;
            mem_wdata_r  <= 32'h0;
            mem_wstrb_r  <= 4'h0;
            hit_count_r  <= 32'h0;
            miss_count_r <= 32'h0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cpu_ready_r <= 1'b0;
                    if (cpu.valid) begin
                        addr_r     <= cpu.addr;
                        wdata_r    <= cpu.wdata;
                        wstrb_r    <= cpu.wstrb;
                        instr_r    <= cpu.instr;
                        refilled_r <= 1'b0;
                        if (cpu.addr[31:28] != 4'h0) begin
                            state_r <= S_BYPASS;
                        end else if (cpu.wstrb != 4'h0) begin
                            state_r <= S_WRITE;
                        end else begin
                            state_r <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (hit_s) begin
                        cpu_rdata_r <= data_r[idx_s][word_s];
                        cpu_ready_r <= 1'b1;
                        if (!refilled_r) begin
                            hit_count_r <= hit_count_r + 32'd1;
                        end
                        state_r <= S_DONE;
                    end else begin
                        miss_count_r <= miss_count_r + 32'd1;
                        cnt_r        <= '0;
                        state_r      <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    // Each word is a separate request; dropping valid between
                    // words lets the memory model restart its delay counter.
                    if (!mem_valid_r) begin
                        mem_valid_r <= 1'b1;
                        mem_instr_r <= instr_r;
                        mem_addr_r  <= {addr_r[31:2+WW], cnt_r, 2'b00};
                        mem_wdata_r <= 32'h0;
                        mem_wstrb_r <= 4'h0;
                    end else if (mem.ready) begin
                        mem_valid_r <= 1'b0;
                        if (last_s) begin
                            valid_r[idx_s] <= 1'b1;
                            refilled_r     <= 1'b1;
                            cnt_r          <= '0;
                            state_r        <= S_LOOKUP;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                S_WRITE, S_BYPASS: begin
                    if (!mem_valid_r) begin
                        mem_valid_r <= 1'b1;
                        mem_instr_r <= instr_r;
                        mem_addr_r  <= addr_r;
                        mem_wdata_r <= wdata_r;
                        mem_wstrb_r <= wstrb_r;
                    end else if (mem.ready) begin
                        mem_valid_r <= 1'b0;
                        if ((state_r == S_BYPASS) && (wstrb_r == 4'h0)) begin
                            cpu_rdata_r <= mem.rdata;
                        end
                        cpu_ready_r <= 1'b1;
                        state_r     <= S_DONE;
                    end
                end
                S_DONE: begin
                    cpu_ready_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    cpu_ready_r <= 1'b0;
                    mem_valid_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays: refill fills words, write hits merge bytes
    always_ff @(posedge clk) begin
        if (!reset && (state_r == S_REFILL) && mem_done_s) begin
            data_r[idx_s][cnt_r] <= mem.rdata;
            if (last_s) begin
                tag_r[idx_s] <= tag_s;
            end
        end else if (!reset && (state_r == S_WRITE) && mem_done_s && hit_s) begin
            data_r[idx_s][word_s] <= merge_bytes(data_r[idx_s][word_s], wdata_r, wstrb_r);
        end
    end

    assign cpu.ready  = cpu_ready_r;
    assign cpu.rdata  = cpu_rdata_r;
    assign mem.valid  = mem_valid_r;
    assign mem.instr  = mem_instr_r;
    assign mem.addr   = mem_addr_r;
    assign mem.wdata  = mem_wdata_r;
    assign mem.wstrb  = mem_wstrb_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: directed CPU accesses, a delayed memory
// model checking forwarded requests, and a CPU-side response monitor.
module tb_l1_dcache;
    localparam int MEM_DLY = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } mreq_t;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
    } cres_t;

    logic        clk;
    logic        reset;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    int          checks;
    int          errors;
    logic [31:0] mem_word [0:1023];
    mreq_t       exp_mem_q [$];
    cres_t       exp_cpu_q [$];

    l1_dcache_if cpu_bus ();
    l1_dcache_if mem_bus ();

    l1_dcache #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu_bus),
        .mem        (mem_bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic ins);
        mreq_t e;
        e.addr = a; e.wdata = wd; e.wstrb = ws; e.instr = ins;
        exp_mem_q.push_back(e);
    endtask

    task automatic exp_line(input logic [31:0] base, input logic ins);
        for (int w = 0; w < 4; w++) begin
            exp_mem(base + 32'(w * 4), 32'h0, 4'h0, ins);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic ins, input logic [31:0] exp_rd, input int exp_lat);
        cres_t r;
        int    n;
        r.is_read = (ws == 4'h0);
        r.rdata   = exp_rd;
        exp_cpu_q.push_back(r);
        @(negedge clk);
        cpu_bus.valid = 1'b1;
        cpu_bus.addr  = a;
        cpu_bus.wdata = wd;
        cpu_bus.wstrb = ws;
        cpu_bus.instr = ins;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_bus.ready !== 1'b1 && n < 200);
        if (cpu_bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL cpu_ready_timeout addr=%h actual=no_ready expected=ready", a);
        end else if (exp_lat >= 0) begin
            chk("latency", 32'(n), 32'(exp_lat));
        end
        @(posedge clk);
        #1;
        cpu_bus.valid = 1'b0;
        cpu_bus.instr = 1'b0;
    endtask

    // Delayed memory model: checks each new request against the scoreboard
    initial begin
        int    dly;
        bit    served;
        bit    prev_rdy;
        mreq_t e;
        dly = 0; served = 1'b0; prev_rdy = 1'b0;
        mem_bus.ready = 1'b0;
        mem_bus.rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (prev_rdy) chk("mem_gap_valid", {31'h0, mem_bus.valid}, 32'h0);
            prev_rdy      = 1'b0;
            mem_bus.ready = 1'b0;
            if (mem_bus.valid !== 1'b1) begin
                dly = 0;
                served = 1'b0;
            end else if (!served) begin
                if (dly == 0) begin
                    if (exp_mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected actual=%h expected=no_request", mem_bus.addr);
                    end else begin
                        e = exp_mem_q.pop_front();
                        chk("mem_addr", mem_bus.addr, e.addr);
                        chk("mem_wstrb", {28'h0, mem_bus.wstrb}, {28'h0, e.wstrb});
                        chk("mem_instr", {31'h0, mem_bus.instr}, {31'h0, e.instr});
                        if (e.wstrb != 4'h0) chk("mem_wdata", mem_bus.wdata, e.wdata);
                    end
                end
                if (dly == MEM_DLY) begin
                    mem_bus.ready = 1'b1;
                    if (mem_bus.addr < 32'd4096) begin
                        mem_bus.rdata = mem_word[mem_bus.addr[11:2]];
                        for (int b = 0; b < 4; b++) begin
                            if (mem_bus.wstrb[b])
                                mem_word[mem_bus.addr[11:2]][b*8 +: 8] = mem_bus.wdata[b*8 +: 8];
                        end
                    end else begin
                        mem_bus.rdata = 32'hDEAD_BEEF;
                    end
                    served   = 1'b1;
                    prev_rdy = 1'b1;
                end else begin
                    dly++;
                end
            end
        end
    end

    // CPU-side monitor: pops the expected response on every cpu_ready
    initial begin
        cres_t r;
        forever begin
            @(negedge clk);
            if (cpu_bus.ready === 1'b1) begin
                if (exp_cpu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_unexpected actual=ready expected=idle");
                end else begin
                    r = exp_cpu_q.pop_front();
                    if (r.is_read) chk("cpu_rdata", cpu_bus.rdata, r.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem_word[i] = 32'hC0DE_0000 + 32'(i);
        reset = 1'b1;
        cpu_bus.valid = 1'b0; cpu_bus.instr = 1'b0;
        cpu_bus.addr = 32'h0; cpu_bus.wdata = 32'h0; cpu_bus.wstrb = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", {31'h0, cpu_bus.ready}, 32'h0);
        chk("rst_cpu_rdata", cpu_bus.rdata, 32'h0);
        chk("rst_mem_valid", {31'h0, mem_bus.valid}, 32'h0);
        chk("rst_mem_addr", mem_bus.addr, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_bus.wstrb}, 32'h0);
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
        reset = 1'b0;

        // Cold miss refills the line at 0x40
        exp_line(32'h40, 1'b0);
        access(32'h40, 32'h0, 4'h0, 1'b0, 32'hC0DE_0010, 23);
        chk("miss_after_cold", miss_count, 32'd1);
        chk("hit_after_cold", hit_count, 32'd0);

        // Hits inside the same line
        access(32'h44, 32'h0, 4'h0, 1'b0, 32'hC0DE_0011, 2);
        access(32'h4C, 32'h0, 4'h0, 1'b1, 32'hC0DE_0013, 2);
        chk("hit_after_repeat", hit_count, 32'd2);

        // Write hit goes through to memory and merges low half-word
        access(32'h40, 32'h0, 4'h0, 1'b0, 32'hC0DE_0010, 2);
        exp_mem(32'h40, 32'h1234_5678, 4'b0011, 1'b0);
        access(32'h40, 32'h1234_5678, 4'b0011, 1'b0, 32'h0, 6);
        access(32'h40, 32'h0, 4'h0, 1'b0, 32'hC0DE_5678, 2);
        chk("hit_after_merge", hit_count, 32'd4);
        chk("miss_after_merge", miss_count, 32'd1);

        // Uncached write and read bypass the cache
        exp_mem(32'h1000_0000, 32'h41, 4'b0001, 1'b0);
        access(32'h1000_0000, 32'h41, 4'b0001, 1'b0, 32'h0, 6);
        exp_mem(32'h1000_0004, 32'h0, 4'h0, 1'b0);
        access(32'h1000_0004, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 6);
        chk("hit_after_bypass", hit_count, 32'd4);
        chk("miss_after_bypass", miss_count, 32'd1);

        // Conflicting lines evict each other
        exp_line(32'h0, 1'b1);
        access(32'h0, 32'h0, 4'h0, 1'b1, 32'hC0DE_0000, 23);
        exp_line(32'h400, 1'b0);
        access(32'h400, 32'h0, 4'h0, 1'b0, 32'hC0DE_0100, 23);
        exp_line(32'h0, 1'b0);
        access(32'h0, 32'h0, 4'h0, 1'b0, 32'hC0DE_0000, 23);
        chk("miss_after_conflict", miss_count, 32'd4);

        // Write miss does not allocate; the following read refills from memory
        exp_mem(32'h100, 32'hAAAA_5555, 4'b1111, 1'b0);
        access(32'h100, 32'hAAAA_5555, 4'b1111, 1'b0, 32'h0, 6);
        exp_line(32'h100, 1'b0);
        access(32'h100, 32'h0, 4'h0, 1'b0, 32'hAAAA_5555, 23);
        chk("miss_after_nowalloc", miss_count, 32'd5);
        chk("hit_after_nowalloc", hit_count, 32'd4);

        // Reset while the second refill word is outstanding
        exp_mem(32'h80, 32'h0, 4'h0, 1'b0);
        exp_mem(32'h84, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        cpu_bus.valid = 1'b1; cpu_bus.addr = 32'h80; cpu_bus.wstrb = 4'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_bus.valid === 1'b1 && mem_bus.addr === 32'h84) && n < 200);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL refill_word1_timeout actual=none expected=%h", 32'h84);
        end
        reset = 1'b1;
        cpu_bus.valid = 1'b0;
        @(negedge clk);
        chk("midrst_mem_valid", {31'h0, mem_bus.valid}, 32'h0);
        chk("midrst_cpu_ready", {31'h0, cpu_bus.ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_hit_count", hit_count, 32'h0);
        chk("midrst_miss_count", miss_count, 32'h0);
        exp_line(32'h80, 1'b0);
        access(32'h80, 32'h0, 4'h0, 1'b0, 32'hC0DE_0020, 23);
        access(32'h84, 32'h0, 4'h0, 1'b0, 32'hC0DE_0021, 2);
        chk("post_rst_miss", miss_count, 32'd1);
        chk("post_rst_hit", hit_count, 32'd1);

        repeat (5) @(negedge clk);
        chk("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);
        chk("cpu_q_drained", 32'(exp_cpu_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
